// File: rtl/key_event.sv
// Turns the debounced key level into one-cycle press / release / short-click /
// long-press / auto-repeat events plus a registered "held" level.
module key_event #(
    parameter int LONG_CYCLES   = 100,
    parameter int REPEAT_CYCLES = 20,
    parameter bit REPEAT_EN     = 1'b1,
    parameter int CNT_W         = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic press,
    output logic key_release,
    output logic short_click,
    output logic long_press,
    output logic rpt,
    output logic held
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        LONG = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             k_r;
    logic             rise_s;
    logic             press_nxt_s;
    logic             release_nxt_s;
    logic             short_nxt_s;
    logic             long_nxt_s;
    logic             rpt_nxt_s;
    logic             held_nxt_s;

    assign rise_s = key_in & ~k_r;

    // State, hold counter and previous key sample
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            k_r     <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            k_r     <= key_in;
        end
    end

    // Next-state and counter; a release always beats a terminal count
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (rise_s) begin
                    state_nxt_s = HOLD;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            HOLD: begin
                if (!key_in) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == LONG_LAST) begin
                    state_nxt_s = LONG;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            LONG: begin
                if (!key_in) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == RPT_LAST) begin
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Event decode, registered below so every output is a flop
    always_comb begin
        press_nxt_s   = 1'b0;
        release_nxt_s = 1'b0;
        short_nxt_s   = 1'b0;
        long_nxt_s    = 1'b0;
        rpt_nxt_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (rise_s) begin
                    press_nxt_s = 1'b1;
                end else begin
                    press_nxt_s = 1'b0;
                end
            end
            HOLD: begin
                if (!key_in) begin
                    release_nxt_s = 1'b1;
                    short_nxt_s   = 1'b1;
                end else if (cnt_r == LONG_LAST) begin
                    long_nxt_s    = 1'b1;
                end else begin
                    long_nxt_s    = 1'b0;
                end
            end
            LONG: begin
                if (!key_in) begin
                    release_nxt_s = 1'b1;
                end else if (cnt_r == RPT_LAST) begin
                    rpt_nxt_s     = REPEAT_EN;
                end else begin
                    rpt_nxt_s     = 1'b0;
                end
            end
            default: begin
                press_nxt_s = 1'b0;
            end
        endcase
        held_nxt_s = (state_nxt_s != IDLE);
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            press       <= 1'b0;
            key_release <= 1'b0;
            short_click <= 1'b0;
            long_press  <= 1'b0;
            rpt         <= 1'b0;
            held        <= 1'b0;
        end else begin
            press       <= press_nxt_s;
            key_release <= release_nxt_s;
            short_click <= short_nxt_s;
            long_press  <= long_nxt_s;
            rpt         <= rpt_nxt_s;
            held        <= held_nxt_s;
        end
    end

endmodule

// File: doc/key_event.md
Name: key_event

Overview:
- Sits directly downstream of key_debounce; consumes its clean `key_debounced` level.
- Converts the level into single-cycle events: press, release, short click, long press and auto-repeat.
- Events feed the game's input/cursor control logic.
- Single clock domain. The input is already debounced and synchronous to clk, so the block has no synchronizer.

Parameters:
- LONG_CYCLES, 100, number of clk cycles the key must be held after the press event before long_press fires; legal range ≥ 2.
- REPEAT_CYCLES, 20, clk cycles between successive rpt pulses once in long-hold; legal range ≥ 1.
- REPEAT_EN, 1, 1 enables auto-repeat; 0 means rpt is never asserted.
- CNT_W, 16, hold counter width; must hold max(LONG_CYCLES, REPEAT_CYCLES) − 1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- key_in  input  1  debounced key level from key_debounce (1 = pressed).
- press  output  1  one-cycle pulse on the press event.
- release  output  1  one-cycle pulse on the release event.
- short_click  output  1  one-cycle pulse on a release that occurs before long_press fired.
- long_press  output  1  one-cycle pulse when the hold reaches LONG_CYCLES.
- rpt  output  1  one-cycle auto-repeat pulse during long-hold.
- held  output  1  level; 1 while state ≠ IDLE.

Behaviour:
- All outputs are registered. Each pulse is high for exactly one cycle, following the clock edge that detects the condition.
- Reset (rst=1 at an edge):
  - state=IDLE, cnt=0, k_r=0.
  - All outputs 0.
  - Reset mid-hold produces no release pulse.
- k_r holds key_in sampled at the previous edge. Rising edge = key_in & ~k_r; falling edge = ~key_in & k_r.
- A key already high when reset deasserts produces a press at the first edge after reset, because k_r resets to 0.
- FSM states: IDLE, HOLD, LONG.
- IDLE:
  - Rising edge → HOLD, cnt←0, press←1.
  - Otherwise stay in IDLE.
- HOLD:
  - key_in=0 → IDLE, release←1, short_click←1, cnt←0.
  - key_in=1 and cnt==LONG_CYCLES−1 → LONG, long_press←1, cnt←0.
  - Otherwise cnt←cnt+1.
  - Resulting timing: if press is high after edge E0, long_press is high after edge E0+LONG_CYCLES.
- LONG:
  - key_in=0 → IDLE, release←1, cnt←0. short_click stays 0.
  - key_in=1 and cnt==REPEAT_CYCLES−1 → cnt←0, rpt←REPEAT_EN.
  - Otherwise cnt←cnt+1.
  - Resulting timing: rpt fires at edges L+REPEAT_CYCLES, L+2·REPEAT_CYCLES, … where L is the long_press edge.
- Simultaneous events:
  - Release sampled at the same edge where cnt hits its terminal value: release wins.
  - In HOLD this gives release+short_click and no long_press. In LONG it gives release and no rpt.
- press and release are never asserted in the same cycle.
- A single-cycle key_in high pulse gives press, then release+short_click one cycle later.
- held=1 from the press-pulse cycle through the cycle before the release pulse. held=0 in the release-pulse cycle.
- Counter is used only up to terminal−1 and never wraps.

Test Plan:
- Use LONG_CYCLES=8, REPEAT_CYCLES=3, REPEAT_EN=1 unless stated.
1. rst=1 for 3 cycles with key_in=1 → all outputs 0 during reset; press=1 on the first edge after rst drops; held=1 from that cycle.
2. Hold key_in=1 for 4 cycles after press, then 0 → no long_press; release=1 and short_click=1 in the same cycle; held=0.
3. Hold key_in=1 for 20 cycles → long_press exactly 8 cycles after press; rpt at +11, +14, +17, +20; on release, release=1 and short_click=0.
4. Same as test 3 with REPEAT_EN=0 → long_press at +8; rpt never asserted.
5. Release timed to the terminal edge (key_in falls so that the edge at press+8 samples 0) → release+short_click; long_press stays 0 for the whole test.
6. Assert rst during LONG (press+10) → all outputs 0 next cycle; no release pulse. Keep key_in=1 → a new press fires after rst deasserts.
